// File: rtl/dbg_pkg.sv
// dbg_pkg: shared debounce state encoding and hex-to-7-segment constants for dbg_probe_display
package dbg_pkg;
  typedef enum logic [1:0] {IDLE, PRESS_WAIT, PRESSED, REL_WAIT} deb_state_e;
  localparam logic [6:0] SEG_ZERO  = 7'b1111110;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;
  // segment order a..g from msb to lsb, active-high; entry 15 first
  localparam logic [15:0][6:0] SEG_TAB = {
    7'b1000111, 7'b1001111, 7'b0111101, 7'b1001110,
    7'b0011111, 7'b1110111, 7'b1111011, 7'b1111111,
    7'b1110000, 7'b1011111, 7'b1011011, 7'b0110011,
    7'b1111001, 7'b1101101, 7'b0110000, 7'b1111110
  };
  function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
    return SEG_TAB[h];
  endfunction
endpackage

// File: rtl/dbg_probe_display_key_debounce.sv
// key_debounce: two-flop key synchroniser plus debounce FSM emitting one registered pulse per accepted press
module key_debounce
  import dbg_pkg::*;
#(
  parameter int DEB_CYCLES = 50000
) (
  input  logic clk,
  input  logic rst,
  input  logic key_i,
  output logic pulse_o
);
  localparam int CNT_W = $clog2(DEB_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEB_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  logic [1:0] sync_q, sync_d;
  deb_state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic pulse_q, pulse_d;
  logic key_s;
  assign key_s = sync_q[1];
  always_comb begin
    sync_d = {sync_q[0], key_i};
    state_d = state_q;
    cnt_d = cnt_q;
    pulse_d = 1'b0;
    case (state_q)
      IDLE: if (key_s) begin
        state_d = PRESS_WAIT;
        cnt_d = CNT_ONE;
      end
      PRESS_WAIT: if (!key_s) begin
        state_d = IDLE;
        cnt_d = '0;
      end else if (cnt_q == CNT_MAX) begin
        state_d = PRESSED;
        pulse_d = 1'b1;
      end else cnt_d = cnt_q + CNT_ONE;
      PRESSED: if (!key_s) begin
        state_d = REL_WAIT;
        cnt_d = CNT_ONE;
      end
      REL_WAIT: if (key_s) begin
        state_d = PRESSED;
        cnt_d = '0;
      end else if (cnt_q == CNT_MAX) state_d = IDLE;
      else cnt_d = cnt_q + CNT_ONE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      sync_q <= '0;
      state_q <= IDLE;
      cnt_q <= '0;
      pulse_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      state_q <= state_d;
      cnt_q <= cnt_d;
      pulse_q <= pulse_d;
    end
  end
  assign pulse_o = pulse_q;
endmodule

// File: rtl/dbg_probe_display.sv
// dbg_probe_display: probe-to-LED pager with debounced step counter on two 7-seg digits; DBG_DIFF_EN shows slice XOR last-step snapshot
module dbg_probe_display
  import dbg_pkg::*;
#(
  parameter int CH_NUM     = 8,
  parameter int DATA_W     = 32,
  parameter int LED_W      = 16,
  parameter int DEB_CYCLES = 50000,
  parameter int SEL_W      = (CH_NUM > 1) ? $clog2(CH_NUM) : 1,
  parameter int PG_W       = (DATA_W / LED_W > 1) ? $clog2(DATA_W / LED_W) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     key_i,
  input  logic [SEL_W-1:0]         sel_i,
  input  logic [PG_W-1:0]          page_i,
  input  logic                     freeze_i,
  input  logic [CH_NUM*DATA_W-1:0] probe_i,
  output logic [LED_W-1:0]         led_o,
  output logic                     step_pulse_o,
  output logic [7:0]               step_cnt_o,
  output logic [6:0]               seg1_o,
  output logic [6:0]               seg0_o
);
  localparam int PAGES = DATA_W / LED_W;
  logic pulse;
  logic [LED_W-1:0] slice, view, led_q, led_d;
  logic [7:0] cnt_q, cnt_d;
  logic [6:0] seg0_q, seg0_d, seg1_q, seg1_d;
  key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
    .clk(clk),
    .rst(rst),
    .key_i(key_i),
    .pulse_o(pulse)
  );
  // out-of-range channel or page selects read as zero
  assign slice = (int'(sel_i) < CH_NUM && int'(page_i) < PAGES)
               ? LED_W'(probe_i >> (int'(sel_i) * DATA_W + int'(page_i) * LED_W)) : '0;
`ifdef DBG_DIFF_EN
  logic [LED_W-1:0] snap_q, snap_d;
  always_comb snap_d = pulse ? slice : snap_q;
  always_ff @(posedge clk) begin
    if (!rst) snap_q <= '0;
    else snap_q <= snap_d;
  end
  assign view = slice ^ snap_q;
`else
  assign view = slice;
`endif
  always_comb begin
    led_d = freeze_i ? led_q : view;
    cnt_d = cnt_q + {7'd0, pulse};
    seg0_d = hex_to_seg(cnt_q[3:0]);
    seg1_d = hex_to_seg(cnt_q[7:4]);
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      led_q <= '0;
      cnt_q <= '0;
      seg0_q <= SEG_ZERO;
      seg1_q <= SEG_ZERO;
    end else begin
      led_q <= led_d;
      cnt_q <= cnt_d;
      seg0_q <= seg0_d;
      seg1_q <= seg1_d;
    end
  end
  assign led_o = led_q;
  assign step_pulse_o = pulse;
  assign step_cnt_o = cnt_q;
  assign seg0_o = seg0_q;
  assign seg1_o = seg1_q;
endmodule

// File: tb/tb_dbg_probe_display.sv
// tb_dbg_probe_display: table vectors, randomized traffic against a behavioural model, and key-path corner sequences
module tb_dbg_probe_display;
  localparam int DEB = 4;
  logic clk = 1'b0;
  logic rst, key_i, freeze_i;
  logic [1:0] sel_i;
  logic [0:0] page_i;
  logic [127:0] probe_i;
  logic [15:0] led_o;
  logic step_pulse_o;
  logic [7:0] step_cnt_o;
  logic [6:0] seg1_o, seg0_o;
  logic [31:0] ch [4];
  always #5 clk = ~clk;
  assign probe_i = {ch[3], ch[2], ch[1], ch[0]};
  dbg_probe_display #(
    .CH_NUM(4), .DATA_W(32), .LED_W(16), .DEB_CYCLES(DEB), .SEL_W(2), .PG_W(1)
  ) dut (
    .clk(clk), .rst(rst), .key_i(key_i), .sel_i(sel_i), .page_i(page_i),
    .freeze_i(freeze_i), .probe_i(probe_i), .led_o(led_o),
    .step_pulse_o(step_pulse_o), .step_cnt_o(step_cnt_o),
    .seg1_o(seg1_o), .seg0_o(seg0_o)
  );
  int n_vec = 0, n_err = 0;
  logic [15:0] led_e;
  logic pulse_e, k1, k2, lvl;
  logic [7:0] cnt_e;
  logic [6:0] seg0_e, seg1_e;
  int run;
  logic [6:0] hex7 [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                            7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};
  typedef struct {
    logic [31:0] c2;
    logic [1:0] sel;
    logic pg;
    logic frz;
    logic [15:0] exp;
  } vec_t;
  vec_t tv [6];
  function automatic logic [15:0] cur_slice();
    return page_i[0] ? ch[sel_i][31:16] : ch[sel_i][15:0];
  endfunction
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  // debounced level flips after DEB consecutive synchronised samples that disagree with it
  task automatic model_step();
    if (!rst) begin
      led_e = '0; pulse_e = 1'b0; cnt_e = '0; seg0_e = 7'h7E; seg1_e = 7'h7E;
      k1 = 1'b0; k2 = 1'b0; lvl = 1'b0; run = 0;
    end else begin
      seg0_e = hex7[cnt_e[3:0]];
      seg1_e = hex7[cnt_e[7:4]];
      if (pulse_e) cnt_e = cnt_e + 8'd1;
      if (!freeze_i) led_e = cur_slice();
      pulse_e = 1'b0;
      if (k2 != lvl) begin
        run++;
        if (run == DEB) begin
          lvl = k2;
          run = 0;
          pulse_e = lvl;
        end
      end else run = 0;
      k2 = k1;
      k1 = key_i;
    end
  endtask
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    chk("led", led_o, led_e);
    chk("pulse", step_pulse_o, pulse_e);
    chk("cnt", step_cnt_o, cnt_e);
    chk("seg0", seg0_o, seg0_e);
    chk("seg1", seg1_o, seg1_e);
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int lat, np;
    tv[0] = '{32'hDEAD_BEEF, 2'd2, 1'b1, 1'b0, 16'hDEAD};
    tv[1] = '{32'hDEAD_BEEF, 2'd2, 1'b0, 1'b0, 16'hBEEF};
    tv[2] = '{32'h0000_1234, 2'd2, 1'b0, 1'b1, 16'hBEEF};
    tv[3] = '{32'h0000_1234, 2'd2, 1'b0, 1'b0, 16'h1234};
    tv[4] = '{32'h0000_1234, 2'd2, 1'b1, 1'b0, 16'h0000};
    tv[5] = '{32'h0000_1234, 2'd1, 1'b1, 1'b0, 16'hCAFE};
    rst = 1'b0; key_i = 1'b0; freeze_i = 1'b0; sel_i = '0; page_i = '0;
    foreach (ch[i]) ch[i] = '0;
    ch[1] = 32'hCAFE_F00D;
    repeat (3) tick();
    chk("rst_led", led_o, 0);
    chk("rst_pulse", step_pulse_o, 0);
    chk("rst_cnt", step_cnt_o, 0);
    chk("rst_seg0", seg0_o, 7'h7E);
    chk("rst_seg1", seg1_o, 7'h7E);
    rst = 1'b1;
    tick();
    for (int i = 0; i < 6; i++) begin
      ch[2] = tv[i].c2; sel_i = tv[i].sel; page_i = tv[i].pg; freeze_i = tv[i].frz;
      tick();
      chk("tbl_led", led_o, tv[i].exp);
    end
    repeat (300) begin
      foreach (ch[i]) ch[i] = $urandom;
      sel_i = 2'($urandom_range(0, 3));
      page_i = 1'($urandom_range(0, 1));
      freeze_i = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 2) == 0) key_i = ~key_i;
      tick();
    end
    key_i = 1'b0; freeze_i = 1'b0;
    rst = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    key_i = 1'b1; lat = 0; np = 0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (step_pulse_o && lat == 0) lat = i;
      np += int'(step_pulse_o);
    end
    chk("press_latency", lat, 6);
    chk("press_pulses", np, 1);
    key_i = 1'b0;
    tick();
    chk("press_cnt", step_cnt_o, 1);
    chk("press_seg0", seg0_o, 7'h30);
    chk("press_seg1", seg1_o, 7'h7E);
    repeat (8) tick();
    np = 0;
    for (int i = 0; i < 14; i++) begin
      key_i = (i < 4) ? ~i[0] : 1'b0;
      tick();
      np += int'(step_pulse_o);
    end
    chk("bounce_pulses", np, 0);
    chk("bounce_cnt", step_cnt_o, 1);
    for (int p = 0; p < 256; p++) begin
      key_i = 1'b1;
      repeat (7) tick();
      key_i = 1'b0;
      repeat (7) tick();
      if (p == 8'hAD) begin
        chk("af_cnt", step_cnt_o, 8'hAF);
        chk("af_seg1", seg1_o, 7'h77);
        chk("af_seg0", seg0_o, 7'h47);
      end
      if (p == 254) begin
        chk("wrap_cnt", step_cnt_o, 0);
        chk("wrap_seg1", seg1_o, 7'h7E);
        chk("wrap_seg0", seg0_o, 7'h7E);
      end
    end
    chk("wrap_final", step_cnt_o, 1);
    key_i = 1'b1;
    repeat (4) tick();
    rst = 1'b0;
    tick();
    chk("mid_rst_led", led_o, 0);
    chk("mid_rst_pulse", step_pulse_o, 0);
    chk("mid_rst_cnt", step_cnt_o, 0);
    chk("mid_rst_seg0", seg0_o, 7'h7E);
    chk("mid_rst_seg1", seg1_o, 7'h7E);
    rst = 1'b1; lat = 0; np = 0;
    for (int i = 1; i <= 12; i++) begin
      tick();
      if (step_pulse_o && lat == 0) lat = i;
      np += int'(step_pulse_o);
    end
    chk("rearm_latency", lat, 6);
    chk("rearm_pulses", np, 1);
    key_i = 1'b0;
    repeat (8) tick();
    chk("rearm_cnt", step_cnt_o, 1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
